fns_enc_seq_9: RTL and testbench

- Sequential Fibonacci-numeral-system (FNS) encoder for the CAC link. It sits directly upstream of the 9-bit FNS decoder.
- Converts a binary data word into a CODE_W-bit codeword, MSB first, by greedy compare-subtract against a runtime weight vector, one bit per cycle.
- Bit positions cleared in en_flag are skipped, which supports the local adjustable-FNS mode.
- Valid/ready on both sides. The codeword and en_flag it emits feed the decoder unchanged.

---
 rtl/fns_enc_seq_9_pkg.sv | 23 ++
 rtl/fns_enc_seq_9_greedy_step.sv | 20 ++
 rtl/fns_enc_seq_9.sv | 126 ++++++++++++
 tb/tb_fns_enc_seq_9.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fns_enc_seq_9_pkg.sv
// Shared widths, default Fibonacci weights and FSM state type for the
// sequential FNS encoder and its greedy step.
package fns_enc_seq_9_pkg;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_CODE_W = 9;
  localparam int DEF_WGT_W  = 6;

  // Weights for bit8..bit0; bit0 sits in the least significant slice.
  localparam logic [DEF_CODE_W*DEF_WGT_W-1:0] DEF_WGT =
    {6'd34, 6'd21, 6'd13, 6'd8, 6'd5, 6'd3, 6'd2, 6'd1, 6'd1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fns_enc_seq_9_greedy_step.sv
// One compare-subtract step of the greedy FNS encoder: emit a 1 and subtract
// the weight when the position is enabled and the remainder covers it.
module fns_greedy_step
  import fns_enc_seq_9_pkg::*;
#(
  parameter int CMP_W = DEF_DATA_W
) (
  input  logic [CMP_W-1:0] rem_i,
  input  logic [CMP_W-1:0] weight_i,
  input  logic             en_i,
  output logic             bit_o,
  output logic [CMP_W-1:0] next_rem_o
);

  always_comb begin
    bit_o      = en_i && (rem_i >= weight_i);
    next_rem_o = bit_o ? (rem_i - weight_i) : rem_i;
  end

endmodule

// File: rtl/fns_enc_seq_9.sv
// Sequential Fibonacci-numeral-system encoder: one codeword bit per cycle,
// MSB first, against weights and enables captured at the accept edge.
module fns_enc_seq_9
  import fns_enc_seq_9_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CODE_W = DEF_CODE_W,
  parameter int WGT_W  = DEF_WGT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         datain,
  input  logic [CODE_W-1:0]         en_flag_in,
  input  logic [CODE_W*WGT_W-1:0]   wgt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CODE_W-1:0]         codeout,
  output logic [CODE_W-1:0]         en_flag_out,
  output logic                      err
);

  localparam int CMP_W = max_int(DATA_W, WGT_W);
  localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  state_e                    state_q, state_d;
  logic [CMP_W-1:0]          rem_q, rem_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CODE_W-1:0]         code_q, code_d;
  logic [CODE_W-1:0]         en_q, en_d;
  logic [CODE_W*WGT_W-1:0]   wgt_q, wgt_d;
  logic                      err_q, err_d;

  logic [CMP_W-1:0]          cur_wgt, data_ext, step_rem;
  logic                      cur_en, step_bit;

  // Select the captured weight/enable for the current position, zero-extended.
  always_comb begin
    cur_wgt  = '0;
    cur_en   = 1'b0;
    data_ext = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_wgt[WGT_W-1:0] = wgt_q[i*WGT_W +: WGT_W];
        cur_en             = en_q[i];
      end
    end
    data_ext[DATA_W-1:0] = datain;
  end

  fns_greedy_step #(.CMP_W(CMP_W)) u_step (
    .rem_i      (rem_q),
    .weight_i   (cur_wgt),
    .en_i       (cur_en),
    .bit_o      (step_bit),
    .next_rem_o (step_rem)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    code_d  = code_q;
    en_d    = en_q;
    wgt_d   = wgt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CALC;
          rem_d   = data_ext;
          en_d    = en_flag_in;
          wgt_d   = wgt;
          idx_d   = IDX_W'(CODE_W - 1);
          code_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_CALC: begin
        for (int i = 0; i < CODE_W; i++) begin
          if (idx_q == IDX_W'(i)) code_d[i] = step_bit;
        end
        rem_d = step_rem;
        // The step at position 0 decides representability.
        if (idx_q == '0) begin
          state_d = S_DONE;
          err_d   = (step_rem != '0);
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      en_q    <= '0;
      wgt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      en_q    <= en_d;
      wgt_q   <= wgt_d;
      err_q   <= err_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign codeout     = code_q;
  assign en_flag_out = en_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fns_enc_seq_9.sv
// Directed bench for the sequential FNS encoder with hand-computed codewords.
module tb_fns_enc_seq_9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  datain;
  logic [8:0]  en_flag_in;
  logic [53:0] wgt;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  codeout;
  logic [8:0]  en_flag_out;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [53:0] wgt_def;

  fns_enc_seq_9 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .datain      (datain),
    .en_flag_in  (en_flag_in),
    .wgt         (wgt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .codeout     (codeout),
    .en_flag_out (en_flag_out),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Offer one word and wait (bounded) for out_valid; lat = edges after accept.
  task automatic send_word(input logic [5:0] d, input logic [8:0] en, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    in_valid   = 1'b1;
    datain     = d;
    en_flag_in = en;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_word();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (codeout !== 9'h000) begin errors++; $display("FAIL rst_codeout got=%h exp=000", codeout); end
    checks++; if (en_flag_out !== 9'h000) begin errors++; $display("FAIL rst_en_flag_out got=%h exp=000", en_flag_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    send_word(6'd20, 9'h1FF, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    checks++; if (codeout !== 9'h054) begin errors++; $display("FAIL basic_code20 got=%h exp=054", codeout); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", err); end
    checks++; if (en_flag_out !== 9'h1FF) begin errors++; $display("FAIL basic_en_out got=%h exp=1ff", en_flag_out); end
    release_word();
  endtask

  task automatic test_values();
    logic [5:0] din [3];
    logic [8:0] exp_code [3];
    int lat;
    din[0] = 6'd63; exp_code[0] = 9'h1A0;
    din[1] = 6'd1;  exp_code[1] = 9'h002;
    din[2] = 6'd0;  exp_code[2] = 9'h000;
    for (int i = 0; i < 3; i++) begin
      send_word(din[i], 9'h1FF, lat);
      checks++; if (codeout !== exp_code[i]) begin errors++; $display("FAIL values_code d=%0d got=%h exp=%h", din[i], codeout, exp_code[i]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL values_err d=%0d got=%b exp=0", din[i], err); end
      release_word();
    end
  endtask

  task automatic test_disabled_bit();
    int lat;
    send_word(6'd20, 9'h1BF, lat);
    checks++; if (codeout !== 9'h03F) begin errors++; $display("FAIL skip6_code got=%h exp=03f", codeout); end
    checks++; if (en_flag_out !== 9'h1BF) begin errors++; $display("FAIL skip6_en_out got=%h exp=1bf", en_flag_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL skip6_err got=%b exp=0", err); end
    release_word();
  endtask

  task automatic test_all_disabled();
    int lat;
    send_word(6'd5, 9'h000, lat);
    checks++; if (codeout !== 9'h000) begin errors++; $display("FAIL noen_code got=%h exp=000", codeout); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL noen_err got=%b exp=1", err); end
    release_word();
  endtask

  task automatic test_stall();
    int lat;
    send_word(6'd63, 9'h1FF, lat);
    for (int c = 0; c < 5; c++) begin
      in_valid   = 1'b1;
      datain     = 6'($urandom_range(0, 63));
      en_flag_in = 9'($urandom);
      wgt        = {22'($urandom), 32'($urandom)};
      @(posedge clk); #1;
      checks++; if (codeout !== 9'h1A0) begin errors++; $display("FAIL stall_code cyc=%0d got=%h exp=1a0", c, codeout); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid cyc=%0d got=%b exp=1", c, out_valid); end
    end
    checks++; if (en_flag_out !== 9'h1FF || err !== 1'b0) begin errors++; $display("FAIL stall_en_err got=%h/%b exp=1ff/0", en_flag_out, err); end
    in_valid = 1'b0;
    wgt      = wgt_def;
    release_word();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_back_idle in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_back_idle out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    in_valid   = 1'b1;
    datain     = 6'd63;
    en_flag_in = 9'h1FF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (codeout !== 9'h000) begin errors++; $display("FAIL midrst_codeout got=%h exp=000", codeout); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_word(6'd20, 9'h1FF, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL midrst_latency got=%0d exp=9", lat); end
    checks++; if (codeout !== 9'h054) begin errors++; $display("FAIL midrst_code got=%h exp=054", codeout); end
    release_word();
  endtask

  initial begin
    wgt_def    = {6'd34, 6'd21, 6'd13, 6'd8, 6'd5, 6'd3, 6'd2, 6'd1, 6'd1};
    wgt        = wgt_def;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    datain     = '0;
    en_flag_in = 9'h1FF;
    test_reset();
    test_basic();
    test_values();
    test_disabled_bit();
    test_all_disabled();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
